blob_bbox_tracker: RTL and testbench

Streaming bounding-box extractor. It sits directly downstream of the morphological opening stage and consumes the cleaned one-bit foreground pixel stream together with that pixel's image coordinates. Each frame it accumulates the bounding rectangle and pixel count of all foreground pixels. At frame end it publishes the result to the display/control logic, and it can optionally overlay the rectangle on the outgoing video.

---
 rtl/blob_bbox_tracker.sv | 169 ++++++++++++++++
 tb/tb_blob_bbox_tracker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/blob_bbox_tracker.sv
// Per-frame bounding box and foreground pixel count of a one-bit pixel stream, with an optional
// rectangle overlay on the outgoing video (enabled by defining BBOX_OVERLAY_EN).
module blob_bbox_tracker #(
    parameter int          H_IMG_RES  = 640,
    parameter int          V_IMG_RES  = 480,
    parameter int          MIN_PIXELS = 64,
    parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
    input  logic        app_clk,
    input  logic        app_rst,
    input  logic [10:0] px_hpos,
    input  logic [10:0] px_vpos,
    input  logic        fg_px,
    input  logic [10:0] vid_hpos,
    input  logic [10:0] vid_vpos,
    input  logic [23:0] vid_data_in,
    output logic [23:0] vid_data_out,
    output logic [10:0] bbox_x_min,
    output logic [10:0] bbox_x_max,
    output logic [10:0] bbox_y_min,
    output logic [10:0] bbox_y_max,
    output logic [18:0] bbox_px_count,
    output logic        bbox_valid,
    output logic        frame_done
);

    localparam logic [10:0] H_LIM   = 11'(H_IMG_RES);
    localparam logic [10:0] V_LIM   = 11'(V_IMG_RES);
    localparam logic [10:0] X_LAST  = 11'(H_IMG_RES - 1);
    localparam logic [10:0] Y_LAST  = 11'(V_IMG_RES - 1);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);
    localparam logic [18:0] CNT_MAX = 19'h7FFFF;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    // Result protocol: frame_done is a one-cycle strobe with no backpressure; bbox_* are
    // loaded on that strobe and held unchanged until the next strobe or reset.
    state_t fsm_state, fsm_state_nxt;

    logic        in_bounds, is_sof, is_eof, take;
    logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [18:0] acc_cnt;
    logic [10:0] base_xmin, base_xmax, base_ymin, base_ymax;
    logic [18:0] base_cnt;
    logic [10:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
    logic [18:0] nxt_cnt;

    assign in_bounds = (px_hpos < H_LIM) && (px_vpos < V_LIM);
    assign is_sof    = in_bounds && (px_hpos == 11'd0) && (px_vpos == 11'd0);
    assign is_eof    = in_bounds && (px_hpos == X_LAST) && (px_vpos == Y_LAST);

    always_ff @(posedge app_clk) begin
        if (app_rst) fsm_state <= WAIT_SOF;
        else         fsm_state <= fsm_state_nxt;
    end

    always_comb begin
        fsm_state_nxt = fsm_state;
        case (fsm_state)
            WAIT_SOF: if (is_sof) fsm_state_nxt = ACCUM;
            ACCUM:    if (is_eof) fsm_state_nxt = COMMIT;
            COMMIT:   fsm_state_nxt = ACCUM;
            default:  fsm_state_nxt = WAIT_SOF;
        endcase
    end

    // Outside ACCUM the accumulators start from the empty box, so a sample taken while
    // leaving WAIT_SOF or during COMMIT is folded into a fresh frame.
    always_comb begin
        take = in_bounds && fg_px && ((fsm_state != WAIT_SOF) || is_sof);
        if (fsm_state == ACCUM) begin
            base_xmin = acc_xmin;
            base_xmax = acc_xmax;
            base_ymin = acc_ymin;
            base_ymax = acc_ymax;
            base_cnt  = acc_cnt;
        end else begin
            base_xmin = 11'h7FF;
            base_xmax = 11'h000;
            base_ymin = 11'h7FF;
            base_ymax = 11'h000;
            base_cnt  = 19'd0;
        end
        nxt_xmin = base_xmin;
        nxt_xmax = base_xmax;
        nxt_ymin = base_ymin;
        nxt_ymax = base_ymax;
        nxt_cnt  = base_cnt;
        if (take) begin
            if (px_hpos < base_xmin) nxt_xmin = px_hpos;
            if (px_hpos > base_xmax) nxt_xmax = px_hpos;
            if (px_vpos < base_ymin) nxt_ymin = px_vpos;
            if (px_vpos > base_ymax) nxt_ymax = px_vpos;
            if (base_cnt != CNT_MAX) nxt_cnt = base_cnt + 19'd1;
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            acc_xmin <= 11'h7FF;
            acc_xmax <= 11'h000;
            acc_ymin <= 11'h7FF;
            acc_ymax <= 11'h000;
            acc_cnt  <= 19'd0;
        end else begin
            acc_xmin <= nxt_xmin;
            acc_xmax <= nxt_xmax;
            acc_ymin <= nxt_ymin;
            acc_ymax <= nxt_ymax;
            acc_cnt  <= nxt_cnt;
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            bbox_x_min    <= 11'd0;
            bbox_x_max    <= 11'd0;
            bbox_y_min    <= 11'd0;
            bbox_y_max    <= 11'd0;
            bbox_px_count <= 19'd0;
            bbox_valid    <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= (fsm_state == COMMIT);
            if (fsm_state == COMMIT) begin
                bbox_px_count <= acc_cnt;
                bbox_valid    <= (acc_cnt >= MIN_CNT);
                // Coordinates of a too-small frame are not published; the previous box stays.
                if (acc_cnt >= MIN_CNT) begin
                    bbox_x_min <= acc_xmin;
                    bbox_x_max <= acc_xmax;
                    bbox_y_min <= acc_ymin;
                    bbox_y_max <= acc_ymax;
                end
            end
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic in_x, in_y, on_row, on_col, on_border;

    always_comb begin
        in_x      = (vid_hpos >= bbox_x_min) && (vid_hpos <= bbox_x_max);
        in_y      = (vid_vpos >= bbox_y_min) && (vid_vpos <= bbox_y_max);
        on_row    = (vid_vpos == bbox_y_min) || (vid_vpos == bbox_y_max);
        on_col    = (vid_hpos == bbox_x_min) || (vid_hpos == bbox_x_max);
        on_border = bbox_valid && ((on_row && in_x) || (on_col && in_y));
    end

    always_ff @(posedge app_clk) begin
        if (app_rst)        vid_data_out <= 24'd0;
        else if (on_border) vid_data_out <= BOX_COLOR;
        else                vid_data_out <= vid_data_in;
    end
`else
    logic vid_pos_unused;
    assign vid_pos_unused = ^{vid_hpos, vid_vpos, BOX_COLOR};

    always_ff @(posedge app_clk) begin
        if (app_rst) vid_data_out <= 24'd0;
        else         vid_data_out <= vid_data_in;
    end
`endif

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Directed-frame bench for blob_bbox_tracker on a reduced 32x24 image; a monitor checks
// each frame_done pulse against expectations queued by the frame driver.
module tb_blob_bbox_tracker;

    localparam int H   = 32;
    localparam int V   = 24;
    localparam int MIN = 4;
`ifdef BBOX_OVERLAY_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [18:0] cnt;
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic        valid;
    } exp_t;

    logic        app_clk = 1'b0;
    logic        app_rst;
    logic [10:0] px_hpos, px_vpos, vid_hpos, vid_vpos;
    logic        fg_px;
    logic [23:0] vid_data_in, vid_data_out;
    logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
    logic [18:0] bbox_px_count;
    logic        bbox_valid, frame_done;

    blob_bbox_tracker #(
        .H_IMG_RES (H),
        .V_IMG_RES (V),
        .MIN_PIXELS(MIN),
        .BOX_COLOR (24'hFF0000)
    ) dut (
        .app_clk      (app_clk),
        .app_rst      (app_rst),
        .px_hpos      (px_hpos),
        .px_vpos      (px_vpos),
        .fg_px        (fg_px),
        .vid_hpos     (vid_hpos),
        .vid_vpos     (vid_vpos),
        .vid_data_in  (vid_data_in),
        .vid_data_out (vid_data_out),
        .bbox_x_min   (bbox_x_min),
        .bbox_x_max   (bbox_x_max),
        .bbox_y_min   (bbox_y_min),
        .bbox_y_max   (bbox_y_max),
        .bbox_px_count(bbox_px_count),
        .bbox_valid   (bbox_valid),
        .frame_done   (frame_done)
    );

    // Clock and cycle counter
    always #5 app_clk = ~app_clk;
    int cyc = 0;
    always @(posedge app_clk) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_fd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge app_clk) begin
        if (frame_done === 1'b1) begin
            check("fd_one_cycle", 32'(prev_fd), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fd_unexpected: pulse at cycle %0d with no frame expected", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                pulses++;
                check("fd_cycle", cyc,                   mon_e.cyc);
                check("count",    32'(bbox_px_count),    32'(mon_e.cnt));
                check("x_min",    32'(bbox_x_min),       32'(mon_e.xmin));
                check("x_max",    32'(bbox_x_max),       32'(mon_e.xmax));
                check("y_min",    32'(bbox_y_min),       32'(mon_e.ymin));
                check("y_max",    32'(bbox_y_max),       32'(mon_e.ymax));
                check("valid",    32'(bbox_valid),       32'(mon_e.valid));
            end
        end
        prev_fd <= (frame_done === 1'b1);
    end

    function automatic exp_t mk(input int cnt, input int xmin, input int xmax,
                                input int ymin, input int ymax, input bit v);
        exp_t e;
        e.cyc   = 32'd0;
        e.cnt   = 19'(cnt);
        e.xmin  = 11'(xmin);
        e.xmax  = 11'(xmax);
        e.ymin  = 11'(ymin);
        e.ymax  = 11'(ymax);
        e.valid = v;
        return e;
    endfunction

    function automatic logic fg_at(input int pat, input int x, input int y);
        case (pat)
            0:       return (x == 2 && y == 3) || (x == 4 && y == 5) || (x == 6 && y == 7);
            1:       return (x >= 10 && x <= 15 && y >= 5 && y <= 9);
            2:       return (x == 0 || x == 31) && (y == 0 || y == 23);
            3:       return (x >= 10 && x <= 20 && y >= 10 && y <= 20);
            default: return 1'b0;
        endcase
    endfunction

    // Driver tasks
    task automatic drive_px(input logic [10:0] h, input logic [10:0] v,
                            input logic f, input logic r);
        @(negedge app_clk);
        px_hpos = h;
        px_vpos = v;
        fg_px   = f;
        app_rst = r;
    endtask

    // tight = next frame's (0,0) follows the last pixel directly (lands in the publish cycle)
    task automatic run_frame(input int pat, input bit tight, input int rst_row,
                             input bit has_exp, input exp_t e);
        exp_t ee;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                drive_px(11'(x), 11'(y), fg_at(pat, x, y), (y == rst_row) && (x < 2));
                if (has_exp && x == H - 1 && y == V - 1) begin
                    ee     = e;
                    ee.cyc = 32'(cyc + 2);
                    exp_q.push_back(ee);
                end
            end
            if (!(tight && y == V - 1)) begin
                drive_px(11'd700, 11'(y), 1'b1, 1'b0);
                drive_px(11'd3, 11'd500, 1'b1, 1'b0);
            end
        end
        if (!tight) repeat (3) drive_px(11'd700, 11'd500, 1'b1, 1'b0);
    endtask

    task automatic vid_probe(input string name, input int h, input int v,
                             input logic [23:0] d, input logic [23:0] exp);
        @(negedge app_clk);
        vid_hpos    = 11'(h);
        vid_vpos    = 11'(v);
        vid_data_in = d;
        @(negedge app_clk);
        check(name, 32'(vid_data_out), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        app_rst     = 1'b1;
        px_hpos     = 11'd700;
        px_vpos     = 11'd500;
        fg_px       = 1'b0;
        vid_hpos    = 11'd0;
        vid_vpos    = 11'd0;
        vid_data_in = 24'd0;
        repeat (3) @(negedge app_clk);
        check("rst_x_min",  32'(bbox_x_min),    32'd0);
        check("rst_x_max",  32'(bbox_x_max),    32'd0);
        check("rst_y_min",  32'(bbox_y_min),    32'd0);
        check("rst_y_max",  32'(bbox_y_max),    32'd0);
        check("rst_count",  32'(bbox_px_count), 32'd0);
        check("rst_valid",  32'(bbox_valid),    32'd0);
        check("rst_fd",     32'(frame_done),    32'd0);
        check("rst_vid",    32'(vid_data_out),  32'd0);

        // Stream before any start of frame, including the frame's last position, is ignored
        drive_px(11'd7, 11'd3, 1'b1, 1'b0);
        drive_px(11'd31, 11'd23, 1'b1, 1'b0);
        drive_px(11'd0, 11'd500, 1'b1, 1'b0);
        drive_px(11'd700, 11'd0, 1'b1, 1'b0);
        repeat (3) drive_px(11'd700, 11'd500, 1'b1, 1'b0);

        run_frame(0, 1'b0, -1, 1'b1, mk(3, 0, 0, 0, 0, 1'b0));
        run_frame(1, 1'b0, -1, 1'b1, mk(30, 10, 15, 5, 9, 1'b1));
        run_frame(0, 1'b0, -1, 1'b1, mk(3, 10, 15, 5, 9, 1'b0));
        run_frame(2, 1'b1, -1, 1'b1, mk(4, 0, 31, 0, 23, 1'b1));
        run_frame(2, 1'b0, -1, 1'b1, mk(4, 0, 31, 0, 23, 1'b1));

        // Reset in the middle of a frame: nothing published for its remainder
        run_frame(1, 1'b0, 12, 1'b0, mk(0, 0, 0, 0, 0, 1'b0));
        check("mid_rst_valid", 32'(bbox_valid),    32'd0);
        check("mid_rst_x_max", 32'(bbox_x_max),    32'd0);
        check("mid_rst_count", 32'(bbox_px_count), 32'd0);
        run_frame(1, 1'b0, -1, 1'b1, mk(30, 10, 15, 5, 9, 1'b1));

        run_frame(3, 1'b0, -1, 1'b1, mk(121, 10, 20, 10, 20, 1'b1));
        vid_probe("vid_left_edge",  10, 15, 24'h000000, OVL ? 24'hFF0000 : 24'h000000);
        vid_probe("vid_bottom",     15, 20, 24'h000000, OVL ? 24'hFF0000 : 24'h000000);
        vid_probe("vid_inside",     15, 15, 24'h000000, 24'h000000);
        vid_probe("vid_right_out",  21, 10, 24'h000000, 24'h000000);
        vid_probe("vid_corner",     20, 20, 24'h00FF00, OVL ? 24'hFF0000 : 24'h00FF00);
        vid_probe("vid_pass",       15, 15, 24'h123456, 24'h123456);
        vid_probe("vid_left_out",    9, 10, 24'hABCDEF, 24'hABCDEF);
        vid_probe("vid_below_col",  10, 21, 24'h111111, 24'h111111);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge app_clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected frame_done pulses never arrived", exp_q.size());
        end
        check("pulse_total", pulses, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
